// File: rtl/idma_cmd_split.sv
// Splits one DMA transfer request into engine commands (C1/C2/C3 beats), one status per chunk,
// and returns one aggregated completion. Define IDMA_SPLIT_4K_EN to keep chunks inside 4KB external pages.
module idma_cmd_split #(
    parameter int MAX_BYTES = 256
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dir,
    input  logic [15:0] req_bytes,
    input  logic [15:0] req_int_addr,
    input  logic [63:0] req_ext_addr,
    output logic [31:0] cmd_m_tdata,
    output logic        cmd_m_tvalid,
    output logic        cmd_m_tlast,
    input  logic        cmd_m_tready,
    input  logic [31:0] stat_s_tdata,
    input  logic        stat_s_tvalid,
    output logic        stat_s_tready,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [1:0]  done_err,
    output logic [15:0] done_bytes
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_C1   = 3'd2;
    localparam logic [2:0] S_C2   = 3'd3;
    localparam logic [2:0] S_C3   = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [16:0] MAX17 = 17'(MAX_BYTES);

    logic [2:0]  state, state_nxt;
    logic        dir_q;
    logic [15:0] rem_q;
    logic [15:0] int_q;
    logic [63:0] ext_q;
    logic [11:0] chunk_q;
    logic [1:0]  err_q;
    logic [15:0] acc_q;

    logic [16:0] chunk17;
    logic        req_hs, cmd_hs, stat_hs;
    logic        st_resp_err, st_mismatch, st_err;
    logic [15:0] rem_after;

    assign req_hs  = (state == S_IDLE) && req_valid && req_ready;
    assign cmd_hs  = cmd_m_tvalid && cmd_m_tready;
    assign stat_hs = stat_s_tvalid && stat_s_tready;

    // Chunk sizing is done at 17 bits so the 4KB distance (up to 4096) never truncates.
    always_comb begin
        chunk17 = ({1'b0, rem_q} < MAX17) ? {1'b0, rem_q} : MAX17;
`ifdef IDMA_SPLIT_4K_EN
        if ((17'd4096 - {5'd0, ext_q[11:0]}) < chunk17)
            chunk17 = 17'd4096 - {5'd0, ext_q[11:0]};
`endif
    end

    assign st_resp_err = (stat_s_tdata[30:28] != 3'b000);
    assign st_mismatch = (stat_s_tdata[15:0] != int_q) || (stat_s_tdata[27:16] != chunk_q) ||
                         (stat_s_tdata[31] != dir_q);
    assign st_err      = st_resp_err || st_mismatch;
    assign rem_after   = rem_q - {4'd0, chunk_q};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_hs) state_nxt = (req_bytes == 16'd0) ? S_DONE : S_CALC;
            S_CALC: state_nxt = S_C1;
            S_C1:   if (cmd_hs) state_nxt = S_C2;
            S_C2:   if (cmd_hs) state_nxt = S_C3;
            S_C3:   if (cmd_hs) state_nxt = S_WAIT;
            S_WAIT: if (stat_hs) state_nxt = (st_err || rem_after == 16'd0) ? S_DONE : S_CALC;
            S_DONE: if (done_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // req_ready is registered so it stays low for the first cycle after reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            dir_q     <= 1'b0;
            rem_q     <= '0;
            int_q     <= '0;
            ext_q     <= '0;
            chunk_q   <= '0;
            err_q     <= '0;
            acc_q     <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == S_IDLE);
            case (state)
                S_IDLE: if (req_hs) begin
                    dir_q <= req_dir;
                    rem_q <= req_bytes;
                    int_q <= req_int_addr;
                    ext_q <= req_ext_addr;
                    err_q <= '0;
                    acc_q <= '0;
                end
                S_CALC: chunk_q <= chunk17[11:0];
                S_WAIT: if (stat_hs) begin
                    err_q <= err_q | {st_mismatch, st_resp_err};
                    if (!st_err) begin
                        int_q <= int_q + {4'd0, chunk_q};
                        ext_q <= ext_q + {52'd0, chunk_q};
                        rem_q <= rem_after;
                        acc_q <= acc_q + {4'd0, chunk_q};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_m_tdata = '0;
        case (state)
            S_C1:    cmd_m_tdata = {dir_q, 3'b000, chunk_q, int_q};
            S_C2:    cmd_m_tdata = ext_q[31:0];
            S_C3:    cmd_m_tdata = ext_q[63:32];
            default: cmd_m_tdata = '0;
        endcase
    end

    assign cmd_m_tvalid  = (state == S_C1) || (state == S_C2) || (state == S_C3);
    assign cmd_m_tlast   = (state == S_C3);
    assign stat_s_tready = (state == S_WAIT);
    assign done_valid    = (state == S_DONE);
    assign done_err      = err_q;
    assign done_bytes    = acc_q;

endmodule
